keypad_scan: RTL and testbench

//   Scans a 4x4 matrix keypad. Drives the columns active-low, one at a time, and reads the rows.

---
 rtl/keypad_if.sv | 10 +
 rtl/keypad_scan.sv | 111 +++++++++++
 tb/tb_keypad_scan.sv | 134 +++++++++++++
 3 files changed

// File: rtl/keypad_if.sv
// keypad_if: keypad matrix pins plus the accepted-key outputs of the scanner
interface keypad_if;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  modport master (input rows, output cols, key_code, key_valid, key_held);
  modport slave (output rows, input cols, key_code, key_valid, key_held);
endinterface

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 active-low keypad column scanner with per-scan debounce and press pulse
module keypad_scan #(
  parameter int SCAN_DIV       = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input logic     clk_in,
  input logic     reset,
  keypad_if.master kp
);
  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  typedef enum logic [1:0] {R_NONE, R_ONE, R_MULTI} res_t;
  typedef enum logic {IDLE, PRESSED} state_t;
  logic [3:0]    rows_meta, rows_sync, low;
  logic [DW-1:0] div;
  logic [1:0]    col_idx, acc_n, low_row;
  logic [3:0]    acc_code, one_code, res_code, cand_code;
  logic [2:0]    low_n, tot;
  logic [CW-1:0] cnt, cnt_nx;
  logic          samp, scan_end, same, accept, clear;
  res_t          res, cand;
  state_t        state, state_nx;
  // two-flop synchroniser; idle level is all rows high
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      rows_meta <= 4'b1111;
      rows_sync <= 4'b1111;
    end else begin
      rows_meta <= kp.rows;
      rows_sync <= rows_meta;
    end
  end
  // classify the current column sample merged with the accumulated scan so far
  always_comb begin
    low      = ~rows_sync;
    samp     = div == DW'(SCAN_DIV - 1);
    scan_end = samp && col_idx == 2'd3;
    low_n    = {2'b0, low[0]} + {2'b0, low[1]} + {2'b0, low[2]} + {2'b0, low[3]};
    low_row  = low[0] ? 2'd0 : low[1] ? 2'd1 : low[2] ? 2'd2 : 2'd3;
    tot      = {1'b0, acc_n} + low_n;
    one_code = (low_n == 3'd1) ? {low_row, col_idx} : acc_code;
    res      = (tot == 3'd0) ? R_NONE : (tot == 3'd1) ? R_ONE : R_MULTI;
    res_code = (res == R_ONE) ? one_code : 4'd0;
    same     = res == cand && res_code == cand_code;
    cnt_nx   = (res == R_MULTI) ? '0 : !same ? CW'(1) : (cnt == CW'(DEBOUNCE_SCANS)) ? cnt : cnt + 1'b1;
  end
  // column divider and registered one-hot-low column drive
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      div     <= '0;
      col_idx <= 2'd0;
      kp.cols <= 4'b1110;
    end else begin
      div <= samp ? '0 : div + 1'b1;
      if (samp) begin
        col_idx <= col_idx + 2'd1;
        kp.cols <= ~(4'b0001 << (col_idx + 2'd1));
      end
    end
  end
  // per-scan accumulator, saturating at two low bits; cleared as each scan completes
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      acc_n    <= 2'd0;
      acc_code <= 4'd0;
    end else if (samp) begin
      acc_n    <= scan_end ? 2'd0 : (tot >= 3'd2) ? 2'd2 : tot[1:0];
      acc_code <= scan_end ? 4'd0 : one_code;
    end
  end
  // debounce candidate and run length of identical scan results
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cand      <= R_NONE;
      cand_code <= 4'd0;
      cnt       <= '0;
    end else if (scan_end) begin
      cand      <= res;
      cand_code <= res_code;
      cnt       <= cnt_nx;
    end
  end
  // state register
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  // accept a stable single key from IDLE; return only on a stable all-released scan
  always_comb begin
    accept   = 1'b0;
    clear    = 1'b0;
    state_nx = state;
    if (scan_end && cnt_nx == CW'(DEBOUNCE_SCANS)) begin
      accept   = state == IDLE && res == R_ONE;
      clear    = state == PRESSED && res == R_NONE;
      state_nx = accept ? PRESSED : clear ? IDLE : state;
    end
  end
  // key outputs; key_code is retained after release
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      kp.key_code  <= 4'd0;
      kp.key_valid <= 1'b0;
      kp.key_held  <= 1'b0;
    end else begin
      kp.key_valid <= accept;
      kp.key_held  <= accept ? 1'b1 : clear ? 1'b0 : kp.key_held;
      if (accept) kp.key_code <= one_code;
    end
  end
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed checks of scan order, debounce, multi-key rejection and reset
module tb_keypad_scan;
  logic        clk_in = 1'b0;
  logic        reset  = 1'b0;
  logic [15:0] pressed = 16'h0;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          pulses  = 0;
  int          p0;
  logic [3:0]  col_exp [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  keypad_if kp ();
  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (.clk_in(clk_in), .reset(reset), .kp(kp));
  always #5 clk_in = ~clk_in;
  // keypad matrix: a pressed key pulls its row low while its column is driven low
  always_comb begin
    kp.rows = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kp.cols[c]) kp.rows[r] = 1'b0;
  end
  // count accepted-press pulses
  always @(posedge clk_in) if (kp.key_valid) pulses <= pulses + 1;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask
  initial begin
    #2 reset = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_cols", 16'(kp.cols), 16'hE);
    check("rst_code", 16'(kp.key_code), 16'h0);
    check("rst_valid", 16'(kp.key_valid), 16'h0);
    check("rst_held", 16'(kp.key_held), 16'h0);
    @(negedge clk_in) reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("idle_cols%0d", i), 16'(kp.cols), 16'(col_exp[i]));
      cyc(4);
    end
    check("idle_valid", 16'(kp.key_valid), 16'h0);
    check("idle_pulses", 16'(pulses), 16'h0);
    pressed = 16'h1 << 9;
    cyc(32);
    check("r2c1_early_held", 16'(kp.key_held), 16'h0);
    check("r2c1_early_pulses", 16'(pulses), 16'h0);
    cyc(16);
    check("r2c1_valid", 16'(kp.key_valid), 16'h1);
    check("r2c1_code", 16'(kp.key_code), 16'h9);
    check("r2c1_held", 16'(kp.key_held), 16'h1);
    cyc(1);
    check("r2c1_valid_drop", 16'(kp.key_valid), 16'h0);
    cyc(15);
    pressed = 16'h0;
    cyc(32);
    check("rel_held_early", 16'(kp.key_held), 16'h1);
    cyc(16);
    check("rel_held", 16'(kp.key_held), 16'h0);
    check("rel_code", 16'(kp.key_code), 16'h9);
    check("rel_pulses", 16'(pulses), 16'h1);
    p0 = pulses;
    for (int i = 0; i < 4; i++) begin
      pressed = (i % 2 == 0) ? 16'h1 << 12 : 16'h0;
      cyc(16);
    end
    pressed = 16'h1 << 12;
    cyc(32);
    check("bounce_early_pulses", 16'(pulses - p0), 16'h0);
    check("bounce_early_held", 16'(kp.key_held), 16'h0);
    cyc(16);
    check("bounce_valid", 16'(kp.key_valid), 16'h1);
    check("bounce_code", 16'(kp.key_code), 16'hC);
    cyc(16);
    check("bounce_pulses", 16'(pulses - p0), 16'h1);
    pressed = 16'h0;
    cyc(48);
    check("bounce_rel_held", 16'(kp.key_held), 16'h0);
    p0 = pulses;
    pressed = 16'h8001;
    cyc(160);
    check("multi_pulses", 16'(pulses - p0), 16'h0);
    check("multi_held", 16'(kp.key_held), 16'h0);
    check("multi_code", 16'(kp.key_code), 16'hC);
    pressed = 16'h0;
    cyc(48);
    p0 = pulses;
    pressed = 16'h1 << 6;
    cyc(48);
    check("r1c2_valid", 16'(kp.key_valid), 16'h1);
    check("r1c2_code", 16'(kp.key_code), 16'h6);
    pressed = 16'h0041;
    cyc(64);
    check("both_code", 16'(kp.key_code), 16'h6);
    check("both_held", 16'(kp.key_held), 16'h1);
    pressed = 16'h0001;
    cyc(64);
    check("rollover_code", 16'(kp.key_code), 16'h6);
    check("rollover_held", 16'(kp.key_held), 16'h1);
    check("rollover_pulses", 16'(pulses - p0), 16'h1);
    pressed = 16'h0;
    cyc(32);
    check("roll_rel_early", 16'(kp.key_held), 16'h1);
    cyc(16);
    check("roll_rel_held", 16'(kp.key_held), 16'h0);
    check("roll_rel_code", 16'(kp.key_code), 16'h6);
    check("roll_rel_pulses", 16'(pulses - p0), 16'h1);
    pressed = 16'h1 << 11;
    cyc(21);
    #2 reset = 1'b1;
    #1;
    check("midrst_cols", 16'(kp.cols), 16'hE);
    check("midrst_code", 16'(kp.key_code), 16'h0);
    check("midrst_held", 16'(kp.key_held), 16'h0);
    check("midrst_valid", 16'(kp.key_valid), 16'h0);
    repeat (2) @(posedge clk_in);
    @(negedge clk_in) reset = 1'b0;
    p0 = pulses;
    cyc(32);
    check("post_rst_early_pulses", 16'(pulses - p0), 16'h0);
    check("post_rst_early_held", 16'(kp.key_held), 16'h0);
    cyc(16);
    check("post_rst_valid", 16'(kp.key_valid), 16'h1);
    check("post_rst_code", 16'(kp.key_code), 16'hB);
    check("post_rst_held", 16'(kp.key_held), 16'h1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
